// File: rtl/npc_exec_ctrl.sv
// Multi-cycle instruction sequencer for the NPC core: steps FETCH/DECODE/MEM/WB,
// gates register-file and PC writes once per instruction, and halts on ebreak, illegal or bus timeout.
//
// state  | meaning
// IDLE   | out of reset, waiting one edge before the first fetch
// FETCH  | ifu_req held, waiting for ifu_ack
// DECODE | one cycle, decoder flags latched on exit
// MEM    | lsu_req held, waiting for lsu_ack
// WB     | one cycle, rf/pc write strobes, instret advances on exit
// HALT   | absorbing until reset
module npc_exec_ctrl #(
    parameter int WDOG_W = 8,
    parameter int CNT_W  = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    output logic             ifu_req_o,
    input  logic             ifu_ack_i,
    output logic             inst_en_o,
    input  logic             dec_regwrite_i,
    input  logic             dec_is_load_i,
    input  logic             dec_is_store_i,
    input  logic             dec_ebreak_i,
    input  logic             dec_illegal_i,
    output logic             lsu_req_o,
    output logic             lsu_wen_o,
    input  logic             lsu_ack_i,
    output logic             rf_we_o,
    output logic             pc_we_o,
    output logic             halt_o,
    output logic [1:0]       halt_code_o,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] instret_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    localparam logic [WDOG_W-1:0] WDOG_MAX = '1;

    state_e            state_q;
    logic [WDOG_W-1:0] wdog_q;
    logic [WDOG_W-1:0] wdog_d;
    logic              wdog_expire;
    logic              ld_q;
    logic              st_q;
    logic              rw_q;
    logic [1:0]        halt_code_q;
    logic [CNT_W-1:0]  instret_q;

    // Expiry is judged on the value the counter would take this cycle, so the
    // halt lands on the cycle the count reaches its maximum; an ack still wins.
    assign wdog_d      = (wdog_q == WDOG_MAX) ? wdog_q : wdog_q + WDOG_W'(1);
    assign wdog_expire = (wdog_d == WDOG_MAX);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            wdog_q      <= '0;
            ld_q        <= 1'b0;
            st_q        <= 1'b0;
            rw_q        <= 1'b0;
            halt_code_q <= 2'd0;
            instret_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q <= S_FETCH;
                    wdog_q  <= '0;
                end
                S_FETCH: begin
                    if (ifu_ack_i) begin
                        state_q <= S_DECODE;
                        wdog_q  <= '0;
                    end else if (wdog_expire) begin
                        state_q     <= S_HALT;
                        halt_code_q <= 2'd3;
                        wdog_q      <= wdog_d;
                    end else begin
                        wdog_q <= wdog_d;
                    end
                end
                S_DECODE: begin
                    ld_q   <= dec_is_load_i;
                    st_q   <= dec_is_store_i;
                    rw_q   <= dec_regwrite_i;
                    wdog_q <= '0;
                    if (dec_ebreak_i) begin
                        state_q     <= S_HALT;
                        halt_code_q <= 2'd1;
                    end else if (dec_illegal_i) begin
                        state_q     <= S_HALT;
                        halt_code_q <= 2'd2;
                    end else if (dec_is_load_i || dec_is_store_i) begin
                        state_q <= S_MEM;
                    end else begin
                        state_q <= S_WB;
                    end
                end
                S_MEM: begin
                    if (lsu_ack_i) begin
                        state_q <= S_WB;
                        wdog_q  <= '0;
                    end else if (wdog_expire) begin
                        state_q     <= S_HALT;
                        halt_code_q <= 2'd3;
                        wdog_q      <= wdog_d;
                    end else begin
                        wdog_q <= wdog_d;
                    end
                end
                S_WB: begin
                    instret_q <= instret_q + CNT_W'(1);
                    state_q   <= S_FETCH;
                    wdog_q    <= '0;
                end
                S_HALT: begin
                    state_q <= S_HALT;
                end
                default: begin
                    state_q <= S_IDLE;
                    wdog_q  <= '0;
                end
            endcase
        end
    end

    assign ifu_req_o   = (state_q == S_FETCH);
    assign inst_en_o   = (state_q == S_FETCH) & ifu_ack_i;
    assign lsu_req_o   = (state_q == S_MEM) & (ld_q | st_q);
    assign lsu_wen_o   = (state_q == S_MEM) & st_q;
    assign rf_we_o     = (state_q == S_WB) & rw_q & ~st_q;
    assign pc_we_o     = (state_q == S_WB);
    assign halt_o      = (state_q == S_HALT);
    assign halt_code_o = halt_code_q;
    assign state_o     = state_q;
    assign instret_o   = instret_q;

endmodule

// File: tb/tb_npc_exec_ctrl.sv
// Self-checking bench for npc_exec_ctrl: directed and random instructions, each expanded
// into its expected phase sequence (fetch/decode/mem/wb/halt) from delays and opcode class.
module tb_npc_exec_ctrl;

    localparam int WDOG_W   = 4;
    localparam int CNT_W    = 32;
    localparam int WDOG_LIM = (1 << WDOG_W) - 1;
    localparam int K_ALU  = 0;
    localparam int K_LD   = 1;
    localparam int K_ST   = 2;
    localparam int K_EBRK = 3;
    localparam int K_ILL  = 4;

    logic             clk;
    logic             rst_ni;
    logic             ifu_req_o;
    logic             ifu_ack_i;
    logic             inst_en_o;
    logic             dec_regwrite_i;
    logic             dec_is_load_i;
    logic             dec_is_store_i;
    logic             dec_ebreak_i;
    logic             dec_illegal_i;
    logic             lsu_req_o;
    logic             lsu_wen_o;
    logic             lsu_ack_i;
    logic             rf_we_o;
    logic             pc_we_o;
    logic             halt_o;
    logic [1:0]       halt_code_o;
    logic [2:0]       state_o;
    logic [CNT_W-1:0] instret_o;
    logic [11:0]      dut_vec;

    int          errors = 0;
    int          checks = 0;
    int unsigned exp_instret = 0;

    npc_exec_ctrl #(.WDOG_W(WDOG_W), .CNT_W(CNT_W)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .ifu_req_o      (ifu_req_o),
        .ifu_ack_i      (ifu_ack_i),
        .inst_en_o      (inst_en_o),
        .dec_regwrite_i (dec_regwrite_i),
        .dec_is_load_i  (dec_is_load_i),
        .dec_is_store_i (dec_is_store_i),
        .dec_ebreak_i   (dec_ebreak_i),
        .dec_illegal_i  (dec_illegal_i),
        .lsu_req_o      (lsu_req_o),
        .lsu_wen_o      (lsu_wen_o),
        .lsu_ack_i      (lsu_ack_i),
        .rf_we_o        (rf_we_o),
        .pc_we_o        (pc_we_o),
        .halt_o         (halt_o),
        .halt_code_o    (halt_code_o),
        .state_o        (state_o),
        .instret_o      (instret_o)
    );

    always #5 clk = ~clk;

    assign dut_vec = {state_o, ifu_req_o, inst_en_o, lsu_req_o, lsu_wen_o,
                      rf_we_o, pc_we_o, halt_o, halt_code_o};

    // Expected outputs for a phase s (0 idle .. 5 halt) of an instruction.
    function automatic logic [11:0] model_vec(int s, bit ifa, bit st, bit rw, int code);
        logic [2:0] sv;
        logic [1:0] cv;
        sv = 3'(s);
        cv = 2'(code);
        return {sv, s == 1, (s == 1) && ifa, s == 3, (s == 3) && st,
                (s == 4) && rw && !st, s == 4, s == 5, cv};
    endfunction

    function automatic bit coin();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(string tag, int s, bit ifa, bit lsa, bit st, bit rw, int code);
        ifu_ack_i = ifa;
        lsu_ack_i = lsa;
        #1;
        check(tag, 64'(dut_vec), 64'(model_vec(s, ifa, st, rw, code)));
        check({tag, "/instret"}, 64'(instret_o), 64'(exp_instret));
        @(posedge clk);
        #1;
    endtask

    task automatic noise_dec();
        dec_regwrite_i = coin();
        dec_is_load_i  = coin();
        dec_is_store_i = coin();
        dec_ebreak_i   = coin();
        dec_illegal_i  = coin();
    endtask

    task automatic do_reset();
        rst_ni      = 1'b0;
        ifu_ack_i   = 1'b1;
        lsu_ack_i   = 1'b0;
        exp_instret = 0;
        repeat (3) begin
            #1;
            check("reset", 64'(dut_vec), 64'd0);
            check("reset/instret", 64'(instret_o), 64'd0);
            @(posedge clk);
            #1;
        end
        rst_ni = 1'b1;
        step("idle", 0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic halted(int code);
        repeat (3) begin
            noise_dec();
            step("halt", 5, coin(), coin(), 1'b0, 1'b0, code);
        end
        do_reset();
    endtask

    // f / m: cycles without ack before the ack in FETCH / MEM (>= WDOG_LIM means never).
    task automatic run_instr(int kind, int f, int m, bit abort_wb);
        bit ld;
        bit st;
        bit rw;
        int nf;
        int nm;
        ld = (kind == K_LD);
        st = (kind == K_ST);
        rw = (kind == K_LD) ? 1'b1 : coin();
        nf = (f >= WDOG_LIM) ? WDOG_LIM : f + 1;
        for (int i = 0; i < nf; i++) begin
            noise_dec();
            step("fetch", 1, i == f, coin(), st, rw, 0);
        end
        if (f >= WDOG_LIM) begin
            halted(3);
            return;
        end
        dec_ebreak_i   = (kind == K_EBRK);
        dec_illegal_i  = (kind == K_EBRK) || (kind == K_ILL);
        dec_is_load_i  = (kind >= K_EBRK) ? coin() : ld;
        dec_is_store_i = (kind >= K_EBRK) ? coin() : st;
        dec_regwrite_i = rw;
        step("decode", 2, coin(), coin(), st, rw, 0);
        if (kind == K_EBRK) begin
            halted(1);
            return;
        end
        if (kind == K_ILL) begin
            halted(2);
            return;
        end
        if (ld || st) begin
            nm = (m >= WDOG_LIM) ? WDOG_LIM : m + 1;
            for (int i = 0; i < nm; i++) begin
                noise_dec();
                step("mem", 3, coin(), i == m, st, rw, 0);
            end
            if (m >= WDOG_LIM) begin
                halted(3);
                return;
            end
        end
        noise_dec();
        if (abort_wb) begin
            do_reset();
            return;
        end
        step("wb", 4, coin(), coin(), st, rw, 0);
        exp_instret++;
    endtask

    initial begin
        int r;
        int kind;
        int f;
        int m;
        clk       = 1'b0;
        rst_ni    = 1'b1;
        ifu_ack_i = 1'b0;
        lsu_ack_i = 1'b0;
        dec_regwrite_i = 1'b0;
        dec_is_load_i  = 1'b0;
        dec_is_store_i = 1'b0;
        dec_ebreak_i   = 1'b0;
        dec_illegal_i  = 1'b0;
        #2;
        do_reset();

        run_instr(K_ALU, 0, 0, 1'b0);
        run_instr(K_ST, 0, 5, 1'b0);
        run_instr(K_LD, 0, 2, 1'b0);
        run_instr(K_ALU, 2, 0, 1'b0);
        run_instr(K_EBRK, 0, 0, 1'b0);
        run_instr(K_ALU, WDOG_LIM, 0, 1'b0);
        run_instr(K_ALU, WDOG_LIM - 1, 0, 1'b0);
        run_instr(K_ST, 1, WDOG_LIM - 1, 1'b0);
        run_instr(K_LD, 1, WDOG_LIM, 1'b0);
        run_instr(K_ILL, 2, 0, 1'b0);
        run_instr(K_ALU, 1, 0, 1'b0);
        run_instr(K_LD, 0, 0, 1'b1);

        repeat (80) begin
            r    = $urandom_range(0, 9);
            kind = (r < 4) ? K_ALU : (r < 6) ? K_LD : (r < 8) ? K_ST : (r == 8) ? K_EBRK : K_ILL;
            f    = ($urandom_range(0, 9) == 0) ? $urandom_range(13, 16) : $urandom_range(0, 3);
            m    = ($urandom_range(0, 9) == 0) ? $urandom_range(13, 16) : $urandom_range(0, 3);
            run_instr(kind, f, m, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
